key_adjust_ctrl: RTL and testbench

//  Upstream front end for the clock time-keeping core: conditions the two raw

---
 rtl/clock_pkg.sv | 25 ++
 rtl/key_channel.sv | 124 ++++++++++++
 rtl/key_adjust_ctrl.sv | 49 ++++
 tb/tb_key_adjust_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock time-keeping design.
// The key-channel FSM encoding and timing constants live here so the core's timebase can reuse them.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DB_PRESS,
        ST_HELD,
        ST_REPEAT,
        ST_DB_REL
    } key_st_t;

    // Default timing at 50 MHz: 20 ms debounce, 0.5 s first repeat, 0.2 s repeat period.
    localparam int unsigned KEY_DB_CYC  = 1_000_000;
    localparam int unsigned KEY_RPT_DLY = 25_000_000;
    localparam int unsigned KEY_RPT_PER = 10_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One time-set key: 2-FF synchroniser, debounce/auto-repeat FSM sharing a single cycle counter,
// registered one-cycle increment pulse and debounced pressed level.
module key_channel
    import clock_pkg::*;
#(
    parameter int unsigned DB_CYC     = KEY_DB_CYC,
    parameter int unsigned REPEAT_DLY = KEY_RPT_DLY,
    parameter int unsigned REPEAT_PER = KEY_RPT_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_n,
    output logic inc,
    output logic lvl
);

    localparam int unsigned CNT_MAX = max3(DB_CYC, REPEAT_DLY, REPEAT_PER);
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_C  = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    key_st_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire_q, fire_d;
    logic             inc_q;
    logic             lvl_q, lvl_d;

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = ONE_C;
                end
            end
            ST_DB_PRESS: begin
                if (s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_HELD: begin
                if (s) begin
                    state_d = ST_DB_REL;
                    cnt_d   = ONE_C;
                end else if (cnt_q == DLY_C) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_REPEAT: begin
                if (s) begin
                    state_d = ST_DB_REL;
                    cnt_d   = ONE_C;
                end else if (cnt_q == PER_C) begin
                    cnt_d  = '0;
                    fire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_DB_REL: begin
                // A low sample while releasing counts as still held and restarts the repeat delay.
                if (!s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        lvl_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_DB_REL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
            inc_q   <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
            // Pulses generated while disabled are dropped, never queued.
            inc_q   <= fire_q & en;
            lvl_q   <= lvl_d;
        end
    end

    assign inc = inc_q;
    assign lvl = lvl_q;

endmodule

// File: rtl/key_adjust_ctrl.sv
// Time-set key front end: two independent key channels (index 0 = minute, 1 = hour).
// Wiring only; all behaviour lives in key_channel.
module key_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DB_CYC     = KEY_DB_CYC,
    parameter int unsigned REPEAT_DLY = KEY_RPT_DLY,
    parameter int unsigned REPEAT_PER = KEY_RPT_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_min_n,
    input  logic key_hr_n,
    output logic min_inc,
    output logic hr_inc,
    output logic min_lvl,
    output logic hr_lvl
);

    logic [1:0] key_n_w;
    logic [1:0] inc_w;
    logic [1:0] lvl_w;

    assign key_n_w = {key_hr_n, key_min_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_channel #(
                .DB_CYC     (DB_CYC),
                .REPEAT_DLY (REPEAT_DLY),
                .REPEAT_PER (REPEAT_PER)
            ) u_key (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .key_n (key_n_w[gi]),
                .inc   (inc_w[gi]),
                .lvl   (lvl_w[gi])
            );
        end
    endgenerate

    assign min_inc = inc_w[0];
    assign hr_inc  = inc_w[1];
    assign min_lvl = lvl_w[0];
    assign hr_lvl  = lvl_w[1];

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Bench for key_adjust_ctrl: directed key scenarios plus random key/en/rst activity,
// checked each cycle against a run-length/hold-time reference model through a scoreboard queue.
module tb_key_adjust_ctrl;

    localparam int DB  = 4;
    localparam int DLY = 12;
    localparam int PER = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic key_min_n = 1'b1;
    logic key_hr_n = 1'b1;
    logic min_inc, hr_inc, min_lvl, hr_lvl;

    int n_pass = 0;
    int n_total = 0;
    int exp_pulses = 0;
    int dut_pulses = 0;

    typedef struct packed {
        logic [1:0] inc;
        logic [1:0] lvl;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    key_adjust_ctrl #(
        .DB_CYC     (DB),
        .REPEAT_DLY (DLY),
        .REPEAT_PER (PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .key_min_n (key_min_n),
        .key_hr_n  (key_hr_n),
        .min_inc   (min_inc),
        .hr_inc    (hr_inc),
        .min_lvl   (min_lvl),
        .hr_lvl    (hr_lvl)
    );

    // Reference model: key delayed by two samples; press accepted after DB+1 consecutive low
    // samples, release after DB+1 consecutive high samples; repeats fire at fixed offsets from
    // the (re)start of the hold. Pulses appear one cycle after they are decided.
    bit m_sh1[2], m_sh2[2], m_pressed[2], m_fire[2];
    int m_low[2], m_high[2], m_hold[2];

    function automatic bit repeat_due(input int t);
        return (t == DLY + 1) || (t > DLY + 1 && ((t - (DLY + 1)) % (PER + 1)) == 0);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   keyv[2];
        bit   s;
        keyv[0] = key_min_n;
        keyv[1] = key_hr_n;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_sh1[k] = 1'b1; m_sh2[k] = 1'b1;
                m_pressed[k] = 1'b0; m_fire[k] = 1'b0;
                m_low[k] = 0; m_high[k] = 0; m_hold[k] = 0;
            end else begin
                s = m_sh2[k];
                m_sh2[k] = m_sh1[k];
                m_sh1[k] = keyv[k];
                e.inc[k] = m_fire[k] && en;
                m_fire[k] = 1'b0;
                if (!m_pressed[k]) begin
                    if (!s) begin
                        m_low[k]++;
                        if (m_low[k] == DB + 1) begin
                            m_pressed[k] = 1'b1;
                            m_low[k] = 0; m_high[k] = 0; m_hold[k] = 0;
                            m_fire[k] = 1'b1;
                        end
                    end else begin
                        m_low[k] = 0;
                    end
                end else if (s) begin
                    m_high[k]++;
                    if (m_high[k] == DB + 1) begin
                        m_pressed[k] = 1'b0;
                        m_high[k] = 0;
                    end
                end else if (m_high[k] > 0) begin
                    m_high[k] = 0;
                    m_hold[k] = 0;
                end else begin
                    m_hold[k]++;
                    if (repeat_due(m_hold[k])) m_fire[k] = 1'b1;
                end
                e.lvl[k] = m_pressed[k];
            end
        end
        exp_q.push_back(e);
        exp_pulses += int'(e.inc[0]) + int'(e.inc[1]);
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, req);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: one scoreboard entry per cycle, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            check_int("scoreboard_entry_present", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_bit("min_inc", min_inc, e.inc[0]);
            check_bit("hr_inc",  hr_inc,  e.inc[1]);
            check_bit("min_lvl", min_lvl, e.lvl[0]);
            check_bit("hr_lvl",  hr_lvl,  e.lvl[1]);
            dut_pulses += int'(min_inc === 1'b1) + int'(hr_inc === 1'b1);
            if (min_inc === 1'b1 || hr_inc === 1'b1)
                $display("pulse t=%0t min_inc=%b hr_inc=%b min_lvl=%b hr_lvl=%b en=%b",
                         $time, min_inc, hr_inc, min_lvl, hr_lvl, en);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pr;
        pr = 8;
        rst = 1'b1; cyc(3); rst = 1'b0; cyc(5);

        // Clean minute press, 8 cycles.
        key_min_n = 1'b0; cyc(8); key_min_n = 1'b1; cyc(15);
        // Bounce rejected.
        key_min_n = 1'b0; cyc(3); key_min_n = 1'b1; cyc(1);
        key_min_n = 1'b0; cyc(2); key_min_n = 1'b1; cyc(12);
        // Hour held 40 cycles: first pulse plus repeats.
        key_hr_n = 1'b0; cyc(40); key_hr_n = 1'b1; cyc(15);
        // Release glitch during hold restarts repeat timing.
        key_min_n = 1'b0; cyc(20); key_min_n = 1'b1; cyc(2);
        key_min_n = 1'b0; cyc(20); key_min_n = 1'b1; cyc(15);
        // Both keys together, then with en low for the whole press.
        key_min_n = 1'b0; key_hr_n = 1'b0; cyc(15);
        key_min_n = 1'b1; key_hr_n = 1'b1; cyc(15);
        en = 1'b0;
        key_min_n = 1'b0; key_hr_n = 1'b0; cyc(15);
        key_min_n = 1'b1; key_hr_n = 1'b1; cyc(15);
        // en rising mid-hold.
        key_hr_n = 1'b0; cyc(22); en = 1'b1; cyc(18); key_hr_n = 1'b1; cyc(15);
        // Reset pulse during repeat with key still held.
        key_hr_n = 1'b0; cyc(25); rst = 1'b1; cyc(1); rst = 1'b0; cyc(20);
        key_hr_n = 1'b1; cyc(15);

        // Random key, enable and reset activity with alternating bouncy and steady phases.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) pr = ($urandom_range(0, 1) == 0) ? 3 : 25;
            if ($urandom_range(0, pr - 1) == 0) key_min_n = ~key_min_n;
            if ($urandom_range(0, pr - 1) == 0) key_hr_n = ~key_hr_n;
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        rst = 1'b0; en = 1'b1; key_min_n = 1'b1; key_hr_n = 1'b1;
        cyc(20);
        #1;
        check_int("pulse_count", dut_pulses, exp_pulses);
        check_bit("pulses_exercised", (exp_pulses > 10) ? 1'b1 : 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
